// File: rtl/message_scroller.sv
// Scrolling message display: a circular buffer of 5-bit character codes viewed
// through a NUM_DIGITS-wide seven-segment window that advances on divider ticks.
module message_scroller #(
    parameter int MSG_LEN    = 16,
    parameter int NUM_DIGITS = 6
) (
    input  logic                       clk_in,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       run,
    input  logic                       dir,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [4:0]                 wr_char,
    output logic [NUM_DIGITS*7-1:0]    seg_out,
    output logic [$clog2(MSG_LEN)-1:0] pos,
    output logic                       wrap
);
    localparam int            AW         = $clog2(MSG_LEN);
    localparam int            SEG_W      = NUM_DIGITS * 7;
    localparam logic [AW-1:0] POS_MAX    = AW'(MSG_LEN - 1);
    localparam logic [AW:0]   LEN_EXT    = (AW + 1)'(MSG_LEN);
    localparam logic [4:0]    CHAR_BLANK = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [AW-1:0]      pos_q;
    logic [AW-1:0]      pos_d;
    logic               wrap_q;
    logic               wrap_d;
    logic [SEG_W-1:0]   seg_q;
    logic [SEG_W-1:0]   seg_d;
    logic [4:0]         buf_q [MSG_LEN];
    logic               tick_s;
    logic               wr_ok_s;

    // Active-low segment pattern, bit order g..a.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h00:   seg = 7'h40;
            5'h01:   seg = 7'h79;
            5'h02:   seg = 7'h24;
            5'h03:   seg = 7'h30;
            5'h04:   seg = 7'h19;
            5'h05:   seg = 7'h12;
            5'h06:   seg = 7'h02;
            5'h07:   seg = 7'h78;
            5'h08:   seg = 7'h00;
            5'h09:   seg = 7'h10;
            5'h0A:   seg = 7'h08;
            5'h0B:   seg = 7'h03;
            5'h0C:   seg = 7'h46;
            5'h0D:   seg = 7'h21;
            5'h0E:   seg = 7'h06;
            5'h0F:   seg = 7'h0E;
            5'h11:   seg = 7'h09;
            5'h12:   seg = 7'h47;
            5'h13:   seg = 7'h0C;
            5'h14:   seg = 7'h41;
            5'h15:   seg = 7'h3F;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Buffer index for digit k; one conditional subtract suffices because both
    // operands are already below MSG_LEN, so non-power-of-two lengths work.
    function automatic logic [AW-1:0] win_idx(input logic [AW-1:0] p, input int k);
        logic [AW:0] sum;
        sum = {1'b0, p} + (AW + 1)'(NUM_DIGITS - 1 - k);
        if (sum >= LEN_EXT) begin
            sum = sum - LEN_EXT;
        end else begin
            sum = sum;
        end
        return sum[AW-1:0];
    endfunction

    assign tick_s  = (state_q == ST_SCROLL) && enable;
    assign wr_ok_s = wr_en && ({1'b0, wr_addr} < LEN_EXT);

    // FSM state register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_SCROLL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCROLL: begin
                if (!run) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_SCROLL;
                end
            end
            ST_PAUSED: begin
                if (run) begin
                    state_d = ST_SCROLL;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: scroll position step and wrap detection.
    always_comb begin
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (tick_s) begin
            if (dir) begin
                if (pos_q == '0) begin
                    pos_d  = POS_MAX;
                    wrap_d = 1'b1;
                end else begin
                    pos_d  = pos_q - AW'(1);
                    wrap_d = 1'b0;
                end
            end else begin
                if (pos_q == POS_MAX) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d  = pos_q + AW'(1);
                    wrap_d = 1'b0;
                end
            end
        end else begin
            pos_d  = pos_q;
            wrap_d = 1'b0;
        end
    end

    // FSM outputs: window decode, dark while idle.
    always_comb begin
        seg_d = {SEG_W{1'b1}};
        if (state_q != ST_IDLE) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                seg_d[7*k +: 7] = seg_decode(buf_q[win_idx(pos_q, k)]);
            end
        end else begin
            seg_d = {SEG_W{1'b1}};
        end
    end

    // Registered position, wrap pulse and segment outputs.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pos_q  <= '0;
            wrap_q <= 1'b0;
            seg_q  <= {SEG_W{1'b1}};
        end else begin
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
            seg_q  <= seg_d;
        end
    end

    // Message buffer; out-of-range addresses are dropped.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                buf_q[i] <= CHAR_BLANK;
            end
        end else if (wr_ok_s) begin
            buf_q[wr_addr] <= wr_char;
        end else begin
            buf_q <= buf_q;
        end
    end

    assign seg_out = seg_q;
    assign pos     = pos_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller: a 16-entry and a 10-entry instance share stimulus
// and are compared against a cycle-level behavioural model of the display.
module tb_message_scroller;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        run;
    logic        dir;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [4:0]  wr_char;
    logic [41:0] seg_a;
    logic [41:0] seg_b;
    logic [3:0]  pos_a;
    logic [3:0]  pos_b;
    logic        wrap_a;
    logic        wrap_b;

    int checks = 0;
    int errors = 0;

    // Model: index 0 mirrors the 16-entry build, index 1 the 10-entry build.
    int          m_len [2];
    logic [4:0]  m_buf [2][16];
    int          m_pos [2];
    int          m_mode [2];   // 0 idle, 1 scrolling, 2 paused
    logic [41:0] m_seg [2];
    logic        m_wrap [2];
    logic [6:0]  seg_tab [32];

    message_scroller #(.MSG_LEN(16), .NUM_DIGITS(6)) dut_a (
        .clk_in(clk), .reset_n(reset_n), .enable(enable), .run(run), .dir(dir),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .seg_out(seg_a), .pos(pos_a), .wrap(wrap_a)
    );

    message_scroller #(.MSG_LEN(10), .NUM_DIGITS(6)) dut_b (
        .clk_in(clk), .reset_n(reset_n), .enable(enable), .run(run), .dir(dir),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .seg_out(seg_b), .pos(pos_b), .wrap(wrap_b)
    );

    initial forever #5 clk = ~clk;

    task automatic init_tab();
        logic [6:0] hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 32; i++) seg_tab[i] = 7'h7F;
        for (int i = 0; i < 16; i++) seg_tab[i] = hex[i];
        seg_tab[17] = 7'h09; seg_tab[18] = 7'h47; seg_tab[19] = 7'h0C;
        seg_tab[20] = 7'h41; seg_tab[21] = 7'h3F;
    endtask

    task automatic model_reset();
        m_len[0] = 16;
        m_len[1] = 10;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) m_buf[d][i] = 5'h10;
            m_pos[d]  = 0;
            m_mode[d] = 0;
            m_seg[d]  = {42{1'b1}};
            m_wrap[d] = 1'b0;
        end
    endtask

    function automatic logic [41:0] m_window(int d);
        logic [41:0] r;
        for (int k = 0; k < 6; k++)
            r[7*k +: 7] = seg_tab[m_buf[d][(m_pos[d] + 5 - k) % m_len[d]]];
        return r;
    endfunction

    // One clock edge of the model, from the inputs held during the cycle.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic [41:0] nseg;
            nseg = (m_mode[d] == 0) ? {42{1'b1}} : m_window(d);
            m_wrap[d] = 1'b0;
            if (m_mode[d] == 1 && enable) begin
                if (!dir) begin
                    m_wrap[d] = (m_pos[d] == m_len[d] - 1);
                    m_pos[d]  = (m_pos[d] + 1) % m_len[d];
                end else begin
                    m_wrap[d] = (m_pos[d] == 0);
                    m_pos[d]  = (m_pos[d] + m_len[d] - 1) % m_len[d];
                end
            end
            if (m_mode[d] == 0 && run) m_mode[d] = 1;
            else if (m_mode[d] == 1 && !run) m_mode[d] = 2;
            else if (m_mode[d] == 2 && run) m_mode[d] = 1;
            if (wr_en && int'(wr_addr) < m_len[d]) m_buf[d][wr_addr] = wr_char;
            m_seg[d] = nseg;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        run = 1'b1; dir = 1'b0; enable = 1'b0;
        cycle();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_char = 5'($urandom_range(0, 15));
            enable = 1'($urandom % 2);
            cycle();
        end
        wr_en = 1'b0; enable = 1'b1;
        cycle(); cycle();
        enable = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (pos_a !== 4'd0) begin errors++; $display("FAIL reset_async_pos: got %0d expected 0", pos_a); end
        checks++; if (seg_a !== {42{1'b1}}) begin errors++; $display("FAIL reset_async_seg: got %h expected all ones", seg_a); end
        checks++; if (pos_b !== 4'd0) begin errors++; $display("FAIL reset_async_pos_b: got %0d expected 0", pos_b); end
        @(posedge clk);
        #3 reset_n = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1;
            cycle();
            checks++; if (pos_a !== 4'd0) begin errors++; $display("FAIL idle_pos pulse %0d: got %0d expected 0", i, pos_a); end
            checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL idle_wrap pulse %0d: got %b expected 0", i, wrap_a); end
            enable = 1'b0;
            cycle();
            checks++; if (seg_a !== {42{1'b1}}) begin errors++; $display("FAIL idle_seg pulse %0d: got %h expected all ones", i, seg_a); end
        end
        run = 1'b1;
        cycle(); cycle();
        checks++; if (seg_a !== {42{1'b1}}) begin errors++; $display("FAIL reset_buffer_blank: got %h expected all ones", seg_a); end
        checks++; if (pos_a !== 4'd0) begin errors++; $display("FAIL reset_scroll_start: got %0d expected 0", pos_a); end
    endtask

    task automatic test_left_scroll();
        dir = 1'b0; enable = 1'b0;
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_char = 5'(a);
            cycle();
        end
        wr_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            enable = 1'b1;
            cycle();
            checks++; if (pos_a !== 4'(i % 16)) begin errors++; $display("FAIL left_pos tick %0d: got %0d expected %0d", i, pos_a, i % 16); end
            checks++; if (wrap_a !== (i == 16)) begin errors++; $display("FAIL left_wrap tick %0d: got %b expected %b", i, wrap_a, i == 16); end
            checks++; if (pos_b !== 4'(m_pos[1]) || wrap_b !== m_wrap[1]) begin errors++; $display("FAIL left_b tick %0d: got pos %0d wrap %b expected pos %0d wrap %b", i, pos_b, wrap_b, m_pos[1], m_wrap[1]); end
            enable = 1'b0;
            cycle();
            checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL left_wrap_pulse tick %0d: got %b expected 0", i, wrap_a); end
            checks++; if (seg_a !== m_seg[0]) begin errors++; $display("FAIL left_seg tick %0d: got %h expected %h", i, seg_a, m_seg[0]); end
            checks++; if (seg_b !== m_seg[1]) begin errors++; $display("FAIL left_seg_b tick %0d: got %h expected %h", i, seg_b, m_seg[1]); end
            if (i == 1) begin
                checks++; if (seg_a[41:35] !== 7'h79) begin errors++; $display("FAIL left_first_leftmost: got %h expected 79", seg_a[41:35]); end
                checks++; if (seg_a[6:0] !== 7'h02) begin errors++; $display("FAIL left_first_rightmost: got %h expected 02", seg_a[6:0]); end
            end
        end
    endtask

    task automatic test_right_scroll();
        dir = 1'b1; enable = 1'b1;
        cycle();
        checks++; if (pos_a !== 4'd15) begin errors++; $display("FAIL right_pos: got %0d expected 15", pos_a); end
        checks++; if (wrap_a !== 1'b1) begin errors++; $display("FAIL right_wrap: got %b expected 1", wrap_a); end
        checks++; if (pos_b !== 4'(m_pos[1]) || wrap_b !== m_wrap[1]) begin errors++; $display("FAIL right_b: got pos %0d wrap %b expected pos %0d wrap %b", pos_b, wrap_b, m_pos[1], m_wrap[1]); end
        enable = 1'b0;
        cycle();
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL right_wrap_pulse: got %b expected 0", wrap_a); end
        checks++; if (seg_a[41:35] !== 7'h0E) begin errors++; $display("FAIL right_leftmost: got %h expected 0e", seg_a[41:35]); end
    endtask

    task automatic test_pause();
        dir = 1'b0; enable = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            cycle();
            checks++; if (pos_a !== 4'((15 + j) % 16)) begin errors++; $display("FAIL held_enable_pos step %0d: got %0d expected %0d", j, pos_a, (15 + j) % 16); end
        end
        enable = 1'b0; run = 1'b0;
        cycle();
        for (int j = 0; j < 3; j++) begin
            enable = 1'b1;
            wr_en = (j == 1); wr_addr = 4'd9; wr_char = 5'h15;
            cycle();
            checks++; if (pos_a !== 4'd4) begin errors++; $display("FAIL pause_pos tick %0d: got %0d expected 4", j, pos_a); end
        end
        enable = 1'b0; wr_en = 1'b0;
        cycle();
        checks++; if (seg_a[6:0] !== 7'h3F || seg_a !== m_seg[0]) begin errors++; $display("FAIL pause_refresh: got %h expected %h", seg_a, m_seg[0]); end
        run = 1'b1; enable = 1'b1;
        cycle();
        checks++; if (pos_a !== 4'd4) begin errors++; $display("FAIL resume_coincident: got %0d expected 4", pos_a); end
        cycle();
        checks++; if (pos_a !== 4'd5) begin errors++; $display("FAIL resume_next: got %0d expected 5", pos_a); end
        checks++; if (pos_b !== 4'(m_pos[1])) begin errors++; $display("FAIL pause_b: got %0d expected %0d", pos_b, m_pos[1]); end
        enable = 1'b0;
    endtask

    task automatic test_write_tick();
        dir = 1'b1; enable = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            cycle();
            checks++; if (pos_a !== 4'(5 - j)) begin errors++; $display("FAIL dir_change_pos step %0d: got %0d expected %0d", j, pos_a, 5 - j); end
        end
        dir = 1'b0; wr_en = 1'b1; wr_addr = 4'd8; wr_char = 5'h11;
        cycle();
        checks++; if (pos_a !== 4'd3) begin errors++; $display("FAIL write_tick_pos: got %0d expected 3", pos_a); end
        enable = 1'b0; wr_en = 1'b0;
        cycle();
        checks++; if (seg_a[6:0] !== 7'h09) begin errors++; $display("FAIL write_tick_digit0: got %h expected 09", seg_a[6:0]); end
        checks++; if (seg_b !== m_seg[1]) begin errors++; $display("FAIL write_tick_b: got %h expected %h", seg_b, m_seg[1]); end
    endtask

    task automatic test_range_and_codes();
        enable = 1'b0;
        for (int a = 10; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_char = 5'h13;
            cycle();
        end
        wr_addr = 4'(m_pos[1]); wr_char = 5'h11;
        cycle();
        wr_en = 1'b0;
        cycle();
        checks++; if (seg_b[41:35] !== 7'h09) begin errors++; $display("FAIL code_h_b: got %h expected 09", seg_b[41:35]); end
        wr_en = 1'b1; wr_char = 5'h1F;
        cycle();
        wr_en = 1'b0;
        cycle();
        checks++; if (seg_b[41:35] !== 7'h7F) begin errors++; $display("FAIL code_1f_blank: got %h expected 7f", seg_b[41:35]); end
        enable = 1'b1;
        for (int j = 0; j < 11; j++) begin
            cycle();
            checks++; if (seg_b !== m_seg[1]) begin errors++; $display("FAIL oor_sweep step %0d: got %h expected %h", j, seg_b, m_seg[1]); end
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            run     = 1'(($urandom % 8) != 0);
            enable  = 1'($urandom % 2);
            dir     = 1'($urandom % 2);
            wr_en   = 1'(($urandom % 3) == 0);
            wr_addr = 4'($urandom % 16);
            wr_char = 5'($urandom % 32);
            cycle();
            checks++; if (pos_a !== 4'(m_pos[0]) || wrap_a !== m_wrap[0]) begin errors++; $display("FAIL rand_a cycle %0d: got pos %0d wrap %b expected pos %0d wrap %b", i, pos_a, wrap_a, m_pos[0], m_wrap[0]); end
            checks++; if (seg_a !== m_seg[0]) begin errors++; $display("FAIL rand_seg_a cycle %0d: got %h expected %h", i, seg_a, m_seg[0]); end
            checks++; if (pos_b !== 4'(m_pos[1]) || wrap_b !== m_wrap[1]) begin errors++; $display("FAIL rand_b cycle %0d: got pos %0d wrap %b expected pos %0d wrap %b", i, pos_b, wrap_b, m_pos[1], m_wrap[1]); end
            checks++; if (seg_b !== m_seg[1]) begin errors++; $display("FAIL rand_seg_b cycle %0d: got %h expected %h", i, seg_b, m_seg[1]); end
        end
        wr_en = 1'b0; enable = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; run = 1'b0; dir = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_char = 5'd0;
        init_tab();
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        test_reset();
        test_left_scroll();
        test_right_scroll();
        test_pause();
        test_write_tick();
        test_range_and_codes();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
